// File: rtl/wb_select_stage.sv
// Write-back select stage: picks one result source, extracts and extends loads
// from memory data, and registers the write-back once per instruction phase cycle.
module wb_select_stage #(
    parameter int  WIDTH         = 32,
    parameter int  NUM_SRC       = 3,
    parameter int  PHASES        = 10,
    parameter int  CAPTURE_PHASE = 9,
    localparam int SEL_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int PHASE_W       = $clog2(PHASES)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [SEL_W-1:0]         wbSrc,
    input  logic [NUM_SRC*WIDTH-1:0] srcData,
    input  logic [2:0]               loadMode,
    input  logic [1:0]               byteOff,
    input  logic                     regWriteIn,
    input  logic [4:0]               writeRegIn,
    output logic [WIDTH-1:0]         wbData,
    output logic [4:0]               wbReg,
    output logic                     wbWrite,
    output logic [PHASE_W-1:0]       phase,
    output logic                     selError
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);
    localparam logic [PHASE_W-1:0] CAP_PHASE  = PHASE_W'(CAPTURE_PHASE);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [4:0]         reg_q, reg_d;
    logic               write_q, write_d;
    logic               err_q, err_d;
    logic               capture_s;
    logic               sel_legal_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic [WIDTH-1:0]   ext_data_s;

    assign capture_s   = !stall && (phase_q == CAP_PHASE);
    assign sel_legal_s = (32'(wbSrc) < 32'(NUM_SRC));

    // Source multiplexer; an out-of-range select leaves zero here.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_data_s = (wbSrc == SEL_W'(i)) ? srcData[i*WIDTH +: WIDTH] : sel_data_s;
        end
    end

    generate
        if (WIDTH == 32) begin : g_load_ext
            logic [7:0]  byte_s;
            logic [15:0] half_s;

            // Load lane extraction and extension, applied to memory data only.
            always_comb begin
                case (byteOff)
                    2'd0:    byte_s = sel_data_s[7:0];
                    2'd1:    byte_s = sel_data_s[15:8];
                    2'd2:    byte_s = sel_data_s[23:16];
                    2'd3:    byte_s = sel_data_s[31:24];
                    default: byte_s = sel_data_s[7:0];
                endcase
                half_s     = byteOff[1] ? sel_data_s[31:16] : sel_data_s[15:0];
                ext_data_s = sel_data_s;
                if (wbSrc == {SEL_W{1'b0}}) begin
                    case (loadMode)
                        3'b001:  ext_data_s = {{24{byte_s[7]}}, byte_s};
                        3'b010:  ext_data_s = {24'h000000, byte_s};
                        3'b011:  ext_data_s = {{16{half_s[15]}}, half_s};
                        3'b100:  ext_data_s = {16'h0000, half_s};
                        default: ext_data_s = sel_data_s;
                    endcase
                end else begin
                    ext_data_s = sel_data_s;
                end
            end
        end else begin : g_no_ext
            assign ext_data_s = sel_data_s;
        end
    endgenerate

    // Next-state: phase advance and one capture per instruction.
    always_comb begin
        phase_d = phase_q;
        data_d  = data_q;
        reg_d   = reg_q;
        write_d = 1'b0;
        err_d   = err_q;
        if (!stall) begin
            phase_d = (phase_q == LAST_PHASE) ? {PHASE_W{1'b0}} : phase_q + PHASE_W'(1);
        end else begin
            phase_d = phase_q;
        end
        if (capture_s) begin
            reg_d = writeRegIn;
            if (sel_legal_s) begin
                data_d  = ext_data_s;
                write_d = regWriteIn;
            end else begin
                data_d  = {WIDTH{1'b0}};
                write_d = 1'b0;
                err_d   = 1'b1;
            end
        end else begin
            write_d = 1'b0;
        end
    end

    // State and output registers; reset drops any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q <= {PHASE_W{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            reg_q   <= 5'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    assign wbData   = data_q;
    assign wbReg    = reg_q;
    assign wbWrite  = write_q;
    assign phase    = phase_q;
    assign selError = err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: default and small-phase instances
// compared against an arithmetic reference model of the write-back behaviour.
module tb_wb_select_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  wbSrc = 2'd0;
    logic [95:0] srcData = 96'd0;
    logic [2:0]  loadMode = 3'd0;
    logic [1:0]  byteOff = 2'd0;
    logic        regWriteIn = 1'b0;
    logic [4:0]  writeRegIn = 5'd0;
    logic [31:0] wbData;
    logic [4:0]  wbReg;
    logic        wbWrite;
    logic [3:0]  phase;
    logic        selError;

    logic         stall2 = 1'b0;
    logic [1:0]   wbSrc2 = 2'd3;
    logic [127:0] srcData2 = 128'd0;
    logic [2:0]   loadMode2 = 3'd0;
    logic [1:0]   byteOff2 = 2'd0;
    logic         regWriteIn2 = 1'b1;
    logic [4:0]   writeRegIn2 = 5'd9;
    logic [31:0]  wbData2;
    logic [4:0]   wbReg2;
    logic         wbWrite2;
    logic [2:0]   phase2;
    logic         selError2;

    int n_cmp = 0;
    int n_err = 0;

    int P[2] = '{10, 5};
    int C[2] = '{9, 2};
    int N[2] = '{3, 4};
    int          m_phase[2];
    logic [31:0] m_data[2];
    logic [4:0]  m_reg[2];
    logic        m_write[2];
    logic        m_err[2];

    wb_select_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .wbSrc(wbSrc), .srcData(srcData),
        .loadMode(loadMode), .byteOff(byteOff), .regWriteIn(regWriteIn),
        .writeRegIn(writeRegIn), .wbData(wbData), .wbReg(wbReg), .wbWrite(wbWrite),
        .phase(phase), .selError(selError)
    );

    wb_select_stage #(.WIDTH(32), .NUM_SRC(4), .PHASES(5), .CAPTURE_PHASE(2)) dut2 (
        .clock(clock), .reset(reset), .stall(stall2), .wbSrc(wbSrc2), .srcData(srcData2),
        .loadMode(loadMode2), .byteOff(byteOff2), .regWriteIn(regWriteIn2),
        .writeRegIn(writeRegIn2), .wbData(wbData2), .wbReg(wbReg2), .wbWrite(wbWrite2),
        .phase(phase2), .selError(selError2)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_ext(logic [31:0] w, int sel, int mode, int off);
        logic [31:0] b;
        logic [31:0] h;
        if (sel != 0) return w;
        b = (w >> (8 * off)) & 32'h000000FF;
        h = (w >> (16 * (off / 2))) & 32'h0000FFFF;
        case (mode)
            1:       return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            2:       return b;
            3:       return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            4:       return h;
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0;
            m_data[k]  = 32'd0;
            m_reg[k]   = 5'd0;
            m_write[k] = 1'b0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(int k, logic st, int sel, logic [127:0] src, int mode, int off,
                              logic rw, logic [4:0] wr);
        if (!st && m_phase[k] == C[k]) begin
            m_reg[k] = wr;
            if (sel >= N[k]) begin
                m_data[k]  = 32'd0;
                m_write[k] = 1'b0;
                m_err[k]   = 1'b1;
            end else begin
                m_data[k]  = ref_ext(32'(src >> (32 * sel)), sel, mode, off);
                m_write[k] = rw;
            end
        end else begin
            m_write[k] = 1'b0;
        end
        if (!st) m_phase[k] = (m_phase[k] + 1) % P[k];
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) begin
            model_reset();
        end else begin
            model_edge(0, stall, int'(wbSrc), {32'd0, srcData}, int'(loadMode), int'(byteOff),
                       regWriteIn, writeRegIn);
            model_edge(1, stall2, int'(wbSrc2), srcData2, int'(loadMode2), int'(byteOff2),
                       regWriteIn2, writeRegIn2);
        end
        #1;
    endtask

    task automatic run_to_phase(int target);
        int guard = 0;
        while (m_phase[0] != target && guard < 40) begin
            tick();
            guard++;
        end
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_cmp++;
        if ({wbData, wbReg, wbWrite, phase, selError} !== 43'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h required 0", {wbData, wbReg, wbWrite, phase, selError});
        end
        tick();
        tick();
        n_cmp++;
        if ({wbData2, wbReg2, wbWrite2, phase2, selError2} !== 42'd0 || phase !== 4'd0) begin
            n_err++;
            $display("FAIL reset_held: got phase %0d phase2 %0d, required 0", phase, phase2);
        end
        #6;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int pulses = 0;
        wbSrc = 2'd1;
        srcData = {$urandom, 32'hDEADBEEF, $urandom};
        regWriteIn = 1'b1;
        writeRegIn = 5'd5;
        loadMode = 3'($urandom_range(0, 7));
        byteOff = 2'($urandom_range(0, 3));
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (wbWrite === 1'b1) pulses++;
            if (k < 10) begin
                n_cmp++;
                if (phase !== 4'(k) || wbWrite !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_count: got phase %0d write %b, required phase %0d write 0", phase, wbWrite, k);
                end
            end
        end
        n_cmp++;
        if (wbData !== 32'hDEADBEEF || wbReg !== 5'd5 || wbWrite !== 1'b1 || phase !== 4'd0) begin
            n_err++;
            $display("FAIL basic_capture: got data %h reg %0d write %b phase %0d, required deadbeef 5 1 0",
                     wbData, wbReg, wbWrite, phase);
        end
        srcData = {$urandom, $urandom, $urandom};
        writeRegIn = 5'd17;
        tick();
        if (wbWrite === 1'b1) pulses++;
        n_cmp++;
        if (pulses != 1 || wbData !== 32'hDEADBEEF || wbReg !== 5'd5 || phase !== 4'd1) begin
            n_err++;
            $display("FAIL basic_hold: got pulses %0d data %h reg %0d phase %0d, required 1 deadbeef 5 1",
                     pulses, wbData, wbReg, phase);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  modes[4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [1:0]  offs[4]  = '{2'd1, 2'd1, 2'd2, 2'd0};
        logic [31:0] exps[4]  = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'h000080FF};
        wbSrc = 2'd0;
        regWriteIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            srcData = {$urandom, $urandom, 32'h123480FF};
            loadMode = modes[i];
            byteOff = offs[i];
            run_to_phase(9);
            tick();
            n_cmp++;
            if (wbData !== exps[i] || wbWrite !== 1'b1) begin
                n_err++;
                $display("FAIL load_%0d: got %h write %b, required %h write 1", i, wbData, wbWrite, exps[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] v = $urandom;
        wbSrc = 2'd2;
        srcData = {v, $urandom, $urandom};
        regWriteIn = 1'b1;
        writeRegIn = 5'd12;
        run_to_phase(9);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (phase !== 4'd9 || wbWrite !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: got phase %0d write %b, required 9 0", phase, wbWrite);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++;
        if (wbWrite !== 1'b1 || wbData !== v || wbReg !== 5'd12 || phase !== 4'd0) begin
            n_err++;
            $display("FAIL stall_release: got write %b data %h reg %0d phase %0d, required 1 %h 12 0",
                     wbWrite, wbData, wbReg, phase, v);
        end
    endtask

    task automatic test_sel_error();
        logic [31:0] v = $urandom;
        wbSrc = 2'd3;
        srcData = {$urandom, v, $urandom};
        regWriteIn = 1'b1;
        writeRegIn = 5'd7;
        run_to_phase(9);
        tick();
        n_cmp++;
        if (wbData !== 32'd0 || wbWrite !== 1'b0 || selError !== 1'b1 || wbReg !== 5'd7) begin
            n_err++;
            $display("FAIL sel_illegal: got data %h write %b err %b reg %0d, required 0 0 1 7",
                     wbData, wbWrite, selError, wbReg);
        end
        wbSrc = 2'd1;
        run_to_phase(9);
        tick();
        n_cmp++;
        if (selError !== 1'b1 || wbData !== v || wbWrite !== 1'b1) begin
            n_err++;
            $display("FAIL sel_sticky: got err %b data %h write %b, required 1 %h 1", selError, wbData, wbWrite, v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v = $urandom;
        run_to_phase(5);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({wbData, wbReg, wbWrite, phase, selError} !== 43'd0 || phase2 !== 3'd0 || selError2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got %h phase2 %0d, required 0", {wbData, wbReg, wbWrite, phase, selError}, phase2);
        end
        tick();
        #3;
        reset = 1'b1;
        wbSrc = 2'd1;
        srcData = {$urandom, v, $urandom};
        regWriteIn = 1'b1;
        writeRegIn = 5'd21;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (k < 10) begin
                if (phase !== 4'(k) || wbWrite !== 1'b0 || selError !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_restart: got phase %0d write %b err %b, required %0d 0 0",
                             phase, wbWrite, selError, k);
                end
            end else begin
                if (phase !== 4'd0 || wbWrite !== 1'b1 || wbData !== v || wbReg !== 5'd21) begin
                    n_err++;
                    $display("FAIL reset_first_capture: got phase %0d write %b data %h, required 0 1 %h",
                             phase, wbWrite, wbData, v);
                end
            end
        end
    endtask

    task automatic test_params();
        int pulses = 0;
        int last = -1;
        wbSrc2 = 2'd3;
        regWriteIn2 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            srcData2 = {$urandom, $urandom, $urandom, $urandom};
            loadMode2 = 3'($urandom_range(0, 7));
            byteOff2 = 2'($urandom_range(0, 3));
            writeRegIn2 = 5'($urandom_range(0, 31));
            tick();
            n_cmp++;
            if (phase2 !== 3'(m_phase[1]) || wbWrite2 !== m_write[1] || wbData2 !== m_data[1] ||
                wbReg2 !== m_reg[1] || selError2 !== 1'b0) begin
                n_err++;
                $display("FAIL params_model: got phase %0d write %b data %h reg %0d, required %0d %b %h %0d",
                         phase2, wbWrite2, wbData2, wbReg2, m_phase[1], m_write[1], m_data[1], m_reg[1]);
            end
            if (wbWrite2 === 1'b1) begin
                pulses++;
                n_cmp++;
                if (phase2 !== 3'd3 || (last >= 0 && k - last != 5)) begin
                    n_err++;
                    $display("FAIL params_spacing: got phase %0d gap %0d, required 3 5", phase2, k - last);
                end
                last = k;
            end
        end
        n_cmp++;
        if (pulses != 3) begin
            n_err++;
            $display("FAIL params_pulses: got %0d required 3", pulses);
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 300; k++) begin
            stall = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 5);
            wbSrc = (r > 3) ? 2'd0 : 2'(r);
            srcData = {$urandom, $urandom, $urandom};
            loadMode = 3'($urandom_range(0, 7));
            byteOff = 2'($urandom_range(0, 3));
            regWriteIn = 1'($urandom_range(0, 1));
            writeRegIn = 5'($urandom_range(0, 31));
            tick();
            n_cmp++;
            if (phase !== 4'(m_phase[0]) || wbWrite !== m_write[0] || wbData !== m_data[0] ||
                wbReg !== m_reg[0] || selError !== m_err[0]) begin
                n_err++;
                $display("FAIL random_%0d: got ph %0d wr %b d %h r %0d e %b, required %0d %b %h %0d %b", k,
                         phase, wbWrite, wbData, wbReg, selError,
                         m_phase[0], m_write[0], m_data[0], m_reg[0], m_err[0]);
            end
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loads();
        test_stall();
        test_sel_error();
        test_reset_mid();
        test_params();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
